// File: rtl/axis_pkt_loopback.sv
// axis_pkt_loopback: buffered AXI4-Stream loopback with store-and-forward/cut-through egress, DPT rewrite and statistics
module axis_pkt_loopback #(
   parameter int         DATA_WIDTH = 32,
   parameter int         USER_WIDTH = 128,
   parameter int         DEPTH_LOG2 = 9,
   parameter bit         STORE_FWD  = 1'b1,
   parameter bit         DPT_MODE   = 1'b0,
   parameter logic [7:0] DPT_CONST  = 8'h01
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic [DATA_WIDTH-1:0]   S_AXIS_DAT_TDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXIS_DAT_TSTRB,
   input  logic [USER_WIDTH-1:0]   S_AXIS_DAT_TUSER,
   input  logic                    S_AXIS_DAT_TLAST,
   input  logic                    S_AXIS_DAT_TVALID,
   output logic                    S_AXIS_DAT_TREADY,
   output logic [DATA_WIDTH-1:0]   M_AXIS_DAT_TDATA,
   output logic [DATA_WIDTH/8-1:0] M_AXIS_DAT_TSTRB,
   output logic [USER_WIDTH-1:0]   M_AXIS_DAT_TUSER,
   output logic                    M_AXIS_DAT_TLAST,
   output logic                    M_AXIS_DAT_TVALID,
   input  logic                    M_AXIS_DAT_TREADY,
   output logic [DEPTH_LOG2:0]     LEVEL,
   output logic [31:0]             PKT_IN_COUNT,
   output logic [31:0]             PKT_OUT_COUNT,
   output logic [15:0]             ESCAPE_COUNT
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int EW = 1 + USER_WIDTH + SW + DATA_WIDTH;
   localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] ONE  = 1;

   typedef enum logic [1:0] {WAIT, SEND, ESCAPE} state_t;

   state_t              state_q, state_d;
   logic [EW-1:0]       mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2:0] wr_q, wr_d, vis_q, rd_q, rd_d, pkt_q, pkt_d;
   logic                tready_q;
   logic [15:0]         esc_q, esc_d;
   logic [31:0]         in_q, in_d, out_q, out_d;
   logic                wr_en, rd_en, empty, full, valid, in_last, out_last;
   logic [EW-1:0]       head;
   logic [USER_WIDTH-1:0] user;

   // vis_q lags wr_q by one edge so a freshly written beat appears a cycle after acceptance
   assign wr_en    = S_AXIS_DAT_TVALID && tready_q;
   assign empty    = vis_q == rd_q;
   assign full     = (wr_q - rd_q) == FULL;
   assign valid    = !empty && (!STORE_FWD || state_q != WAIT);
   assign rd_en    = valid && M_AXIS_DAT_TREADY;
   assign head     = empty ? '0 : mem[rd_q[DEPTH_LOG2-1:0]];
   assign in_last  = wr_en && S_AXIS_DAT_TLAST;
   assign out_last = rd_en && head[EW-1];

   assign S_AXIS_DAT_TREADY = tready_q;
   assign M_AXIS_DAT_TVALID = valid;
   assign M_AXIS_DAT_TDATA  = head[DATA_WIDTH-1:0];
   assign M_AXIS_DAT_TSTRB  = head[DATA_WIDTH+SW-1:DATA_WIDTH];
   assign M_AXIS_DAT_TLAST  = head[EW-1];
   assign user              = head[EW-2:DATA_WIDTH+SW];
   assign LEVEL             = wr_q - rd_q;
   assign PKT_IN_COUNT      = in_q;
   assign PKT_OUT_COUNT     = out_q;
   assign ESCAPE_COUNT      = esc_q;

   // egress TUSER: DPT byte replaced by reflected SPT or the constant, zero while empty
   always_comb begin
      M_AXIS_DAT_TUSER        = user;
      M_AXIS_DAT_TUSER[31:24] = empty ? 8'h00 : DPT_MODE ? DPT_CONST : user[23:16];
   end

   // pointer, packet-count and statistics next state
   always_comb begin
      wr_d  = wr_en ? wr_q + ONE : wr_q;
      rd_d  = rd_en ? rd_q + ONE : rd_q;
      pkt_d = (in_last == out_last) ? pkt_q : in_last ? pkt_q + ONE : pkt_q - ONE;
      in_d  = in_last ? in_q + 32'd1 : in_q;
      out_d = out_last ? out_q + 32'd1 : out_q;
   end

   // egress-enable FSM: hold until a whole packet is buffered, escape to cut-through on a jammed full FIFO
   always_comb begin
      state_d = state_q;
      esc_d   = esc_q;
      if (STORE_FWD) begin
         case (state_q)
            WAIT:
               if (pkt_q != '0) state_d = SEND;
               else if (full && S_AXIS_DAT_TVALID) begin
                  state_d = ESCAPE;
                  esc_d   = (esc_q == 16'hFFFF) ? esc_q : esc_q + 16'd1;
               end
            SEND:    if (out_last && pkt_d == '0) state_d = WAIT;
            ESCAPE:  if (out_last) state_d = WAIT;
            default: state_d = WAIT;
         endcase
      end
   end

   // control and statistics registers
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q  <= WAIT;
         wr_q     <= '0;
         vis_q    <= '0;
         rd_q     <= '0;
         pkt_q    <= '0;
         tready_q <= 1'b0;
         esc_q    <= '0;
         in_q     <= '0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         vis_q    <= wr_q;
         rd_q     <= rd_d;
         pkt_q    <= pkt_d;
         tready_q <= (wr_d - rd_d) != FULL;
         esc_q    <= esc_d;
         in_q     <= in_d;
         out_q    <= out_d;
      end
   end

   // beat storage; contents past the pointers are don't-care so no reset is needed
   always_ff @(posedge ACLK) begin
      if (wr_en) mem[wr_q[DEPTH_LOG2-1:0]] <= {S_AXIS_DAT_TLAST, S_AXIS_DAT_TUSER, S_AXIS_DAT_TSTRB, S_AXIS_DAT_TDATA};
   end
endmodule

// File: tb/tb_axis_pkt_loopback.sv
// tb_axis_pkt_loopback: scoreboard bench over three loopback configurations
module tb_axis_pkt_loopback;
   typedef struct packed {
      logic [31:0]  d;
      logic [3:0]   s;
      logic [127:0] u;
      logic         l;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n [3];
   logic [31:0] s_d = '0;
   logic [3:0] s_s = '0;
   logic [127:0] s_u = '0;
   logic s_l = 1'b0;
   logic sv [3];
   logic sr [3];
   logic mr [3];
   logic [31:0] md [3];
   logic [3:0] ms [3];
   logic [127:0] mu [3];
   logic ml [3];
   logic mv [3];
   logic [31:0] pin [3];
   logic [31:0] pout [3];
   logic [15:0] esc [3];
   logic [9:0] a_lvl;
   logic [2:0] b_lvl;
   logic [3:0] c_lvl;
   logic [2:0] bmax;
   beat_t sbq [3][$];
   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   axis_pkt_loopback #(.DEPTH_LOG2(9), .STORE_FWD(1'b1), .DPT_MODE(1'b0)) dut_a (
      .ACLK(clk), .ARESETN(rst_n[0]),
      .S_AXIS_DAT_TDATA(s_d), .S_AXIS_DAT_TSTRB(s_s), .S_AXIS_DAT_TUSER(s_u), .S_AXIS_DAT_TLAST(s_l),
      .S_AXIS_DAT_TVALID(sv[0]), .S_AXIS_DAT_TREADY(sr[0]),
      .M_AXIS_DAT_TDATA(md[0]), .M_AXIS_DAT_TSTRB(ms[0]), .M_AXIS_DAT_TUSER(mu[0]), .M_AXIS_DAT_TLAST(ml[0]),
      .M_AXIS_DAT_TVALID(mv[0]), .M_AXIS_DAT_TREADY(mr[0]),
      .LEVEL(a_lvl), .PKT_IN_COUNT(pin[0]), .PKT_OUT_COUNT(pout[0]), .ESCAPE_COUNT(esc[0]));

   axis_pkt_loopback #(.DEPTH_LOG2(2), .STORE_FWD(1'b1), .DPT_MODE(1'b0)) dut_b (
      .ACLK(clk), .ARESETN(rst_n[1]),
      .S_AXIS_DAT_TDATA(s_d), .S_AXIS_DAT_TSTRB(s_s), .S_AXIS_DAT_TUSER(s_u), .S_AXIS_DAT_TLAST(s_l),
      .S_AXIS_DAT_TVALID(sv[1]), .S_AXIS_DAT_TREADY(sr[1]),
      .M_AXIS_DAT_TDATA(md[1]), .M_AXIS_DAT_TSTRB(ms[1]), .M_AXIS_DAT_TUSER(mu[1]), .M_AXIS_DAT_TLAST(ml[1]),
      .M_AXIS_DAT_TVALID(mv[1]), .M_AXIS_DAT_TREADY(mr[1]),
      .LEVEL(b_lvl), .PKT_IN_COUNT(pin[1]), .PKT_OUT_COUNT(pout[1]), .ESCAPE_COUNT(esc[1]));

   axis_pkt_loopback #(.DEPTH_LOG2(3), .STORE_FWD(1'b0), .DPT_MODE(1'b1), .DPT_CONST(8'h01)) dut_c (
      .ACLK(clk), .ARESETN(rst_n[2]),
      .S_AXIS_DAT_TDATA(s_d), .S_AXIS_DAT_TSTRB(s_s), .S_AXIS_DAT_TUSER(s_u), .S_AXIS_DAT_TLAST(s_l),
      .S_AXIS_DAT_TVALID(sv[2]), .S_AXIS_DAT_TREADY(sr[2]),
      .M_AXIS_DAT_TDATA(md[2]), .M_AXIS_DAT_TSTRB(ms[2]), .M_AXIS_DAT_TUSER(mu[2]), .M_AXIS_DAT_TLAST(ml[2]),
      .M_AXIS_DAT_TVALID(mv[2]), .M_AXIS_DAT_TREADY(mr[2]),
      .LEVEL(c_lvl), .PKT_IN_COUNT(pin[2]), .PKT_OUT_COUNT(pout[2]), .ESCAPE_COUNT(esc[2]));

   // monitor: every egress handshake pops the matching scoreboard queue
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst_n[k] && mv[k] && mr[k]) begin
            nchk++;
            if (sbq[k].size() == 0) begin
               nerr++;
               $display("FAIL extra_beat dut%0d: got data %h, no beat expected", k, md[k]);
            end else begin
               beat_t e;
               e = sbq[k].pop_front();
               if ({md[k], ms[k], mu[k], ml[k]} !== e) begin
                  nerr++;
                  $display("FAIL beat dut%0d: got d=%h s=%h u=%h l=%b, want d=%h s=%h u=%h l=%b",
                           k, md[k], ms[k], mu[k], ml[k], e.d, e.s, e.u, e.l);
               end
            end
         end
      end
   end

   always @(negedge clk) if (b_lvl > bmax) bmax = b_lvl;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic send(input int k, input logic [31:0] d, input logic [7:0] spt, input logic l, input logic [7:0] dpt);
      logic [127:0] u;
      bit ok;
      u = {96'h0123_4567_89AB_CDEF_0F1E_2D3C, 8'hEE, spt, d[15:0]};
      sbq[k].push_back('{d: d, s: d[3:0], u: {u[127:32], dpt, u[23:0]}, l: l});
      s_d = d;
      s_s = d[3:0];
      s_u = u;
      s_l = l;
      sv[k] = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         ok = sr[k];
         @(posedge clk);
         #1;
      end
      sv[k] = 1'b0;
      if (!ok) begin
         nchk++;
         nerr++;
         $display("FAIL send_timeout dut%0d: data %h never accepted, want accepted", k, d);
      end
   endtask

   task automatic wait_pout(input int k, input logic [31:0] target, input string nm);
      for (int n = 0; n < 200 && pout[k] != target; n++) tick();
      chk(nm, pout[k], target);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b1;
         sv[k] = 1'b0;
         mr[k] = 1'b0;
      end
      bmax = '0;
      #2;
      for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
      repeat (3) tick();
      chk("rst_tvalid", mv[0], 0);
      chk("rst_tdata", md[0], 0);
      chk("rst_tuser", mu[0][63:0], 0);
      chk("rst_tlast", ml[0], 0);
      chk("rst_level", a_lvl, 0);
      chk("rst_counts", {pin[0], pout[0]}, 0);
      chk("rst_escape", esc[0], 0);
      chk("rst_tready", sr[0], 0);
      chk("rst_tuser_c", mu[2][31:0], 0);
      for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
      chk("rel_tready_before", sr[0], 0);
      tick();
      chk("rel_tready_after", sr[0], 1);

      mr[0] = 1'b1;
      send(0, 32'h11, 8'h05, 1'b0, 8'h05);
      chk("sf_hold1", mv[0], 0);
      send(0, 32'h22, 8'h05, 1'b0, 8'h05);
      send(0, 32'h33, 8'h05, 1'b0, 8'h05);
      chk("sf_hold3", mv[0], 0);
      send(0, 32'h44, 8'h05, 1'b1, 8'h05);
      chk("sf_hold_last", mv[0], 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("sf_b2b_valid", mv[0], 1);
         tick();
      end
      chk("sf_done_valid", mv[0], 0);
      chk("sf_pkt_in", pin[0], 1);
      chk("sf_pkt_out", pout[0], 1);

      mr[2] = 1'b1;
      send(2, 32'h0000_ABCD, 8'h07, 1'b1, 8'h01);
      chk("ct_valid_n", mv[2], 0);
      tick();
      chk("ct_valid_n1", mv[2], 1);
      chk("ct_dpt", mu[2][31:24], 8'h01);
      chk("ct_len", mu[2][15:0], 16'hABCD);
      wait_pout(2, 1, "ct_pkt_out");

      mr[1] = 1'b1;
      bmax = '0;
      for (int i = 1; i <= 6; i++) send(1, 32'h90 + i, 8'h09, i == 6, 8'h09);
      wait_pout(1, 1, "esc_pkt_out");
      chk("esc_max_level", bmax, 4);
      chk("esc_count", esc[1], 1);
      chk("esc_drained", sbq[1].size(), 0);
      send(1, 32'hA1, 8'h0A, 1'b0, 8'h0A);
      chk("esc_sf_hold1", mv[1], 0);
      send(1, 32'hA2, 8'h0A, 1'b1, 8'h0A);
      chk("esc_sf_hold2", mv[1], 0);
      tick();
      chk("esc_sf_valid", mv[1], 1);
      wait_pout(1, 2, "esc_sf_pkt_out");

      mr[1] = 1'b0;
      send(1, 32'h51, 8'h0B, 1'b1, 8'h0B);
      send(1, 32'h52, 8'h0B, 1'b1, 8'h0B);
      send(1, 32'h53, 8'h0B, 1'b1, 8'h0B);
      chk("bp_level3", b_lvl, 3);
      chk("bp_tready3", sr[1], 1);
      send(1, 32'h54, 8'h0B, 1'b1, 8'h0B);
      chk("bp_level4", b_lvl, 4);
      chk("bp_tready4", sr[1], 0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_valid", mv[1], 1);
         chk("bp_hold_data", {md[1], mu[1][31:16], ml[1]}, {32'h51, 16'h0B0B, 1'b1});
         tick();
      end
      mr[1] = 1'b1;
      wait_pout(1, 6, "bp_pkt_out");
      chk("bp_escape_unchanged", esc[1], 1);
      chk("bp_drained", sbq[1].size(), 0);

      mr[0] = 1'b1;
      send(0, 32'h61, 8'h0C, 1'b0, 8'h0C);
      send(0, 32'h62, 8'h0C, 1'b0, 8'h0C);
      chk("mid_level_pre", a_lvl, 2);
      chk("mid_head_pre", md[0], 32'h61);
      rst_n[0] = 1'b0;
      #1;
      chk("mid_level_rst", a_lvl, 0);
      chk("mid_valid_rst", mv[0], 0);
      chk("mid_data_rst", md[0], 0);
      sbq[0].delete();
      tick();
      rst_n[0] = 1'b1;
      send(0, 32'h71, 8'h0D, 1'b1, 8'h0D);
      wait_pout(0, 1, "mid_pkt_out");
      chk("mid_pkt_in", pin[0], 1);

      repeat (3) tick();
      for (int k = 0; k < 3; k++) chk("final_queue_empty", sbq[k].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end
endmodule
